// File: rtl/calc2_pkg.sv
// Purpose : shared types for the calc2 port driver (commands, response codes, result record).
// Latency : n/a (types and a combinational helper only).
// Backpressure: n/a.
package calc2_pkg;

   // Tag bitmaps are always this wide; NUM_TAGS below 4 simply masks the upper bits.
   localparam int MAX_TAGS = 4;

   typedef enum logic [3:0] {
      NOP = 4'd0,
      ADD = 4'd1,
      SUB = 4'd2,
      SHL = 4'd5,
      SHR = 4'd6
   } cmd_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      OK   = 2'd1,
      ERR  = 2'd2,
      TMO  = 2'd3
   } resp_e;

   typedef logic [1:0] tag_t;

   typedef struct packed {
      resp_e       resp;
      logic [31:0] data;
      tag_t        tag;
   } result_t;

   // Index of the lowest set bit; 0 when none is set (callers check for empty first).
   function automatic tag_t lowest_set(input logic [MAX_TAGS-1:0] v);
      tag_t t;
      t = '0;
      for (int i = MAX_TAGS - 1; i >= 0; i--) begin
         if (v[i]) t = tag_t'(i);
      end
      return t;
   endfunction

endpackage

// File: rtl/calc2_drv_rsp_fifo.sv
// Purpose : synchronous result FIFO with a registered, show-ahead head entry.
// Latency : a push into an empty FIFO is visible on head the next cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
//
// Ports: clk, reset (async active-low), push/push_dat (write side),
//        pop/head (read side, head is zero when empty), full, empty.
module calc2_drv_rsp_fifo
   import calc2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  result_t push_dat,
   input  logic    pop,
   output result_t head,
   output logic    full,
   output logic    empty
);

   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = AW + 1;
   localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

   result_t         mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_inc;
   logic [CNTW-1:0] count, count_nxt;
   logic            push_ok, pop_ok;
   result_t         head_nxt;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign pop_ok     = pop && !empty;
   assign push_ok    = push && (!full || pop_ok);
   assign rd_ptr_inc = ptr_inc(rd_ptr);
   assign count_nxt  = count + CNTW'(push_ok) - CNTW'(pop_ok);

   // head is a register holding the entry that will sit at rd_ptr after this
   // cycle's push/pop, so the consumer never sees a combinational mux.
   always_comb begin
      head_nxt = head;
      if (count_nxt == '0) begin
         head_nxt = '0;
      end else if (pop_ok) begin
         head_nxt = (count > CNTW'(1)) ? mem[rd_ptr_inc] : push_dat;
      end else if (empty) begin
         head_nxt = push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok)  rd_ptr <= rd_ptr_inc;
         count <= count_nxt;
         head  <= head_nxt;
         full  <= (count_nxt == DEPTH_C);
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/calc2_port_driver.sv
// Purpose : issue stage for one calc2 port: tag allocation, two-cycle request, result return.
// Latency : request shows on cmd/data_in the cycle after handshake; result reaches rsp_* one cycle after resp.
// Backpressure: req_ready drops for the op2 cycle and while no tag is free; calc2 responses are never stalled.
//
// Ports: clk, reset (async active-low); host request req_valid/req_ready/req_cmd/req_op1/req_op2;
//        calc2 side cmd/data_in/tag_in (out) and resp/data_out/tag_out (in);
//        host result rsp_valid/rsp_ready/rsp_status/rsp_data/rsp_tag; sticky err_tag.
// Option  : define CALC2_DRV_TIMEOUT_EN for per-tag response timeouts with tag quarantine.
module calc2_port_driver
   import calc2_pkg::*;
#(
   parameter int NUM_TAGS       = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_cmd,
   input  logic [31:0] req_op1,
   input  logic [31:0] req_op2,
   output logic [3:0]  cmd,
   output logic [31:0] data_in,
   output logic [1:0]  tag_in,
   input  logic [1:0]  resp,
   input  logic [31:0] data_out,
   input  logic [1:0]  tag_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [1:0]  rsp_status,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_tag,
   output logic        err_tag
);

   localparam logic [MAX_TAGS-1:0] TAG_MASK = MAX_TAGS'((1 << NUM_TAGS) - 1);

   typedef enum logic {IDLE, SEND_OP2} state_e;
   state_e state_q, state_nxt;

   // busy: allocated until the host pops its result; pend: still waiting for calc2.
   logic [MAX_TAGS-1:0] busy_q, pend_q, quar_q;
   logic [MAX_TAGS-1:0] busy_nxt, pend_nxt, quar_nxt;
   logic [MAX_TAGS-1:0] free_now, free_nxt;
   logic [31:0]         op2_q;
   logic                alloc;
   tag_t                alloc_tag;
   logic                rsp_hit, cap_vld, stray;
   logic                tmo_vld;
   tag_t                tmo_tag;
   logic                push, pop;
   result_t             push_dat, head;
   logic                fifo_empty, unused_fifo_full;
   logic [3:0]          cmd_nxt;
   logic [31:0]         data_nxt;
   tag_t                tag_nxt;
   logic                rdy_nxt;

   // ---------------- response capture ----------------
   assign rsp_hit = (resp != 2'd0);
   assign cap_vld = rsp_hit && pend_q[tag_out];
   assign stray   = rsp_hit && !pend_q[tag_out];
   assign push    = cap_vld || tmo_vld;

   always_comb begin
      push_dat = '0;
      if (cap_vld) begin
         // calc2 code 3 is not a timeout from our side; fold it into ERR.
         push_dat.resp = (resp == OK) ? OK : ERR;
         push_dat.data = data_out;
         push_dat.tag  = tag_out;
      end else if (tmo_vld) begin
         push_dat.resp = TMO;
         push_dat.tag  = tmo_tag;
      end
   end

   calc2_drv_rsp_fifo #(.DEPTH(NUM_TAGS)) u_rsp_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .head     (head),
      .full     (unused_fifo_full),
      .empty    (fifo_empty)
   );

   assign rsp_valid  = !fifo_empty;
   assign rsp_status = head.resp;
   assign rsp_data   = head.data;
   assign rsp_tag    = head.tag;
   assign pop        = rsp_valid && rsp_ready;

   // ---------------- optional timeout ----------------
`ifdef CALC2_DRV_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0]       cnt_q [MAX_TAGS];
   logic [MAX_TAGS-1:0] expired;

   always_comb begin
      for (int i = 0; i < MAX_TAGS; i++) expired[i] = pend_q[i] && (cnt_q[i] == CNT_LAST);
   end

   // A real response owns the single FIFO write port; expired tags hold their
   // count and fire on a later free cycle.
   assign tmo_vld = (|expired) && !cap_vld;
   assign tmo_tag = lowest_set(expired);

   always_comb begin
      quar_nxt = quar_q;
      if (tmo_vld) quar_nxt[tmo_tag] = 1'b1;
      if (rsp_hit && quar_q[tag_out]) quar_nxt[tag_out] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         quar_q <= '0;
         for (int i = 0; i < MAX_TAGS; i++) cnt_q[i] <= '0;
      end else begin
         quar_q <= quar_nxt;
         for (int i = 0; i < MAX_TAGS; i++) begin
            if (alloc && alloc_tag == tag_t'(i)) cnt_q[i] <= '0;
            else if (pend_q[i] && cnt_q[i] != CNT_LAST) cnt_q[i] <= cnt_q[i] + CW'(1);
         end
      end
   end
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
   assign tmo_vld  = 1'b0;
   assign tmo_tag  = '0;
   assign quar_q   = '0;
   assign quar_nxt = '0;
`endif

   // ---------------- tag bitmaps ----------------
   assign free_now  = ~busy_q & ~quar_q & TAG_MASK;
   assign alloc     = (state_q == IDLE) && req_valid && req_ready;
   assign alloc_tag = lowest_set(free_now);

   always_comb begin
      busy_nxt = busy_q;
      pend_nxt = pend_q;
      if (pop)     busy_nxt[head.tag] = 1'b0;
      if (alloc) begin
         busy_nxt[alloc_tag] = 1'b1;
         pend_nxt[alloc_tag] = 1'b1;
      end
      if (cap_vld) pend_nxt[tag_out] = 1'b0;
      if (tmo_vld) pend_nxt[tmo_tag] = 1'b0;
   end

   // req_ready is registered from the post-update bitmap, so a tag freed this
   // cycle can only be allocated from the next cycle on.
   assign free_nxt = ~busy_nxt & ~quar_nxt & TAG_MASK;

   // ---------------- issue FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      cmd_nxt   = NOP;
      data_nxt  = '0;
      tag_nxt   = '0;
      rdy_nxt   = |free_nxt;
      unique case (state_q)
         IDLE: begin
            if (alloc) begin
               state_nxt = SEND_OP2;
               cmd_nxt   = req_cmd;
               data_nxt  = req_op1;
               tag_nxt   = alloc_tag;
               rdy_nxt   = 1'b0;
            end
         end
         SEND_OP2: begin
            state_nxt = IDLE;
            data_nxt  = op2_q;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q    <= '0;
         pend_q    <= '0;
         op2_q     <= '0;
         cmd       <= '0;
         data_in   <= '0;
         tag_in    <= '0;
         req_ready <= 1'b0;
         err_tag   <= 1'b0;
      end else begin
         busy_q    <= busy_nxt;
         pend_q    <= pend_nxt;
         cmd       <= cmd_nxt;
         data_in   <= data_nxt;
         tag_in    <= tag_nxt;
         req_ready <= rdy_nxt;
         if (alloc) op2_q   <= req_op2;
         if (stray) err_tag <= 1'b1;
      end
   end

endmodule
